// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, width helpers and round-robin pick for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  localparam int RR_MAX = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  // Search starts just after the last owner, so that owner is considered last.
  function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] valid,
                                                input int unsigned last,
                                                input int unsigned n);
    logic [RR_MAX-1:0] pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (pick == '0 && valid[idx[4:0]]) pick[idx[4:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// rtl/fifo_rr_picker.sv - combinational round-robin priority encoder
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          valid,
  input  logic [idx_w(NREQ)-1:0]   last,
  output logic [NREQ-1:0]          pick,
  output logic [idx_w(NREQ)-1:0]   pick_idx,
  output logic                     any
);

  localparam int IW = idx_w(NREQ);

  logic [RR_MAX-1:0] v_ext;
  logic [RR_MAX-1:0] p_ext;

  always_comb begin
    v_ext = '0;
    v_ext[NREQ-1:0] = valid;
    p_ext = rr_next(v_ext, int'(unsigned'(last)), NREQ);
    pick = p_ext[NREQ-1:0];
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
    any = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded sharing of the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DSIZE-1:0]         wdata,
  output logic                     winc,
  input  logic                     wfull,
  output logic [idx_w(NREQ)-1:0]   owner_id,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t      state, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   rr_last, rr_d;
  logic [CW-1:0]   beat_cnt, cnt_d;

  logic [IW-1:0]   own_idx;
  logic            acc, withdrawn, own_last, cap_hit, rel;
  logic [NREQ-1:0] cand, pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) own_idx = IW'(i);
    end
  end

  // Ready is combinational so accepted data reaches the FIFO in the same cycle.
  assign req_ready = gnt_q & {NREQ{~wfull & wrst_n}};
  assign acc       = |(req_valid & req_ready);
  assign winc      = acc;
  assign wdata     = (|gnt_q) ? req_data[own_idx*DSIZE +: DSIZE] : '0;
  assign owner_id  = own_idx;
  assign busy      = |gnt_q;

  assign withdrawn = (state == OWN) & ~|(req_valid & gnt_q);
  assign own_last  = |(req_last & gnt_q);
  assign cap_hit   = (beat_cnt == CW'(MAX_BURST - 1));
  assign rel       = withdrawn | (acc & (own_last | cap_hit));
  assign cand      = withdrawn ? (req_valid & ~gnt_q) : req_valid;

  fifo_rr_picker #(.NREQ(NREQ)) u_picker (
    .valid    (cand),
    .last     (rr_last),
    .pick     (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    rr_d    = rr_last;
    cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          gnt_d   = pick_oh;
          rr_d    = pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (acc) cnt_d = beat_cnt + CW'(1);
        if (rel) begin
          if (pick_any) begin
            gnt_d = pick_oh;
            rr_d  = pick_idx;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt_q    <= '0;
      rr_last  <= IW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt_q    <= gnt_d;
      rr_last  <= rr_d;
      beat_cnt <= cnt_d;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge wclk) disable iff (!wrst_n) $onehot0(gnt_q));
  a_no_write_full : assert property (@(posedge wclk) winc |-> !wfull);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int MAX_BURST = 4;
  localparam int DEPTH = 16;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic                  wfull;
  logic [1:0]            owner_id;
  logic                  busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wdata     (wdata),
    .winc      (winc),
    .wfull     (wfull),
    .owner_id  (owner_id),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] src_d[NREQ][$];
  bit         src_l[NREQ][$];
  bit         en[NREQ];
  bit         rd_en;

  logic [7:0] fifo_mem[$];
  logic [7:0] exp_q[$];
  int         own_log[$];
  int         cyc_log[$];

  int m_own;
  int m_cnt;
  int m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int i, input int len, input bit with_last);
    for (int b = 0; b < len; b++) begin
      src_d[i].push_back(8'($urandom));
      src_l[i].push_back(with_last && (b == len - 1));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (src_d[i].size() > 0);
      req_data[i*DSIZE +: DSIZE] = (src_d[i].size() > 0) ? src_d[i][0] : 8'h00;
      req_last[i] = (src_d[i].size() > 0) ? src_l[i][0] : 1'b0;
    end
    wfull = (fifo_mem.size() >= DEPTH);
  endtask

  // One clock: drive, check outputs against the model, advance model, then clock.
  task automatic step();
    logic [NREQ-1:0] er;
    bit ea, wd, rel;
    int p;
    logic [NREQ-1:0] cand;
    logic [7:0] ed;
    drive();
    #1;
    er = '0;
    if (m_own >= 0 && !wfull && wrst_n) er[m_own] = 1'b1;
    ea = (m_own >= 0) && !wfull && wrst_n && req_valid[m_own];
    ed = (m_own >= 0) ? req_data[m_own*DSIZE +: DSIZE] : 8'h00;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("winc", 32'(winc), 32'(ea));
    chk("wdata", 32'(wdata), 32'(ed));
    chk("owner_id", 32'(owner_id), (m_own >= 0) ? m_own : 0);
    chk("busy", 32'(busy), 32'(m_own >= 0));
    if (winc) begin
      own_log.push_back(int'(owner_id));
      cyc_log.push_back(cyc);
      if (fifo_mem.size() < DEPTH) fifo_mem.push_back(wdata);
    end
    if (ea) begin
      exp_q.push_back(ed);
      void'(src_d[m_own].pop_front());
      void'(src_l[m_own].pop_front());
    end
    if (!wrst_n) begin
      m_own = -1; m_cnt = 0; m_rr = NREQ - 1;
    end else if (m_own < 0) begin
      p = pick(req_valid, m_rr);
      if (p >= 0) begin m_own = p; m_cnt = 0; m_rr = p; end
    end else begin
      wd = !req_valid[m_own];
      if (ea) m_cnt++;
      rel = wd || (ea && (req_last[m_own] || m_cnt == MAX_BURST));
      if (rel) begin
        cand = req_valid;
        if (wd) cand[m_own] = 1'b0;
        p = pick(cand, m_rr);
        if (p >= 0) begin m_own = p; m_cnt = 0; m_rr = p; end
        else m_own = -1;
      end
    end
    if (rd_en && fifo_mem.size() > 0 && exp_q.size() > 0 && $urandom_range(99) < 40) begin
      chk("readback", 32'(fifo_mem.pop_front()), 32'(exp_q.pop_front()));
    end
    @(posedge wclk);
    #1;
    cyc++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      src_d[i].delete(); src_l[i].delete(); en[i] = 1'b0;
    end
    fifo_mem.delete(); exp_q.delete(); own_log.delete(); cyc_log.delete();
  endtask

  logic [7:0] t2_dat[NREQ][4];
  int c0;

  initial begin
    m_own = -1; m_cnt = 0; m_rr = NREQ - 1;
    rd_en = 1'b0;
    wrst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    clear_all();
    @(posedge wclk);
    #1;

    // Reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner_id), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    wrst_n = 1'b1;

    // Single requester, three beats, last on the third
    src_d[0].push_back(8'h11); src_l[0].push_back(1'b0);
    src_d[0].push_back(8'h22); src_l[0].push_back(1'b0);
    src_d[0].push_back(8'h33); src_l[0].push_back(1'b1);
    en[0] = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 6; k++) step();
    chk("t1_nwrites", own_log.size(), 3);
    if (own_log.size() == 3) begin
      chk("t1_first_cyc", cyc_log[0], c0 + 1);
      chk("t1_last_cyc", cyc_log[2], c0 + 3);
      chk("t1_rd0", 32'(fifo_mem[0]), 32'h11);
      chk("t1_rd1", 32'(fifo_mem[1]), 32'h22);
      chk("t1_rd2", 32'(fifo_mem[2]), 32'h33);
    end
    chk("t1_idle", 32'(busy), 0);

    // All requesters continuous, never last: 0,1,2,3 four beats each, then full
    clear_all();
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      push_pkt(i, 12, 1'b0);
      for (int b = 0; b < 4; b++) t2_dat[i][b] = src_d[i][b];
      en[i] = 1'b1;
    end
    c0 = cyc;
    for (int k = 0; k < 24; k++) step();
    chk("t2_nwrites", own_log.size(), 16);
    chk("t2_fifo_size", fifo_mem.size(), DEPTH);
    if (own_log.size() == 16 && fifo_mem.size() == DEPTH) begin
      chk("t2_first_cyc", cyc_log[0], c0 + 1);
      chk("t2_no_bubble", cyc_log[15] - cyc_log[0], 15);
      for (int k = 0; k < 16; k++) begin
        chk("t2_owner_seq", own_log[k], k / 4);
        chk("t2_data_order", 32'(fifo_mem[k]), 32'(t2_dat[k/4][k%4]));
      end
    end
    drive();
    chk("t2_wfull", 32'(wfull), 1);

    // Randomized traffic with withdrawals, stalls and a mid-run reset
    clear_all();
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
    for (int t = 0; t < 800; t++) begin
      rd_en = (t % 200) < 140;
      for (int i = 0; i < NREQ; i++) begin
        if (src_d[i].size() == 0 && $urandom_range(99) < 25)
          push_pkt(i, int'($urandom_range(6, 1)), 1'b1);
        en[i] = ($urandom_range(99) < (en[i] ? 92 : 50));
      end
      wrst_n = (t != 400);
      step();
    end
    wrst_n = 1'b1;

    // Reset mid-burst, then requester 0 wins first with all valid
    clear_all();
    rd_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      push_pkt(i, 4, 1'b1);
      en[i] = 1'b1;
    end
    step();
    step();
    step();
    wrst_n = 1'b0;
    step();
    chk("t3_rst_busy", 32'(busy), 0);
    wrst_n = 1'b1;
    step();
    chk("t3_owner0", 32'(owner_id), 0);
    chk("t3_busy", 32'(busy), 1);
    for (int k = 0; k < 4; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
